timebase_selector: RTL and testbench
====================================

Name: timebase_selector

Overview:
- Upstream control stage for the programmable clock divider.
- Turns raw front-panel UP/DOWN push-buttons into a saturating timebase index.
- Drives the divider's 28-bit LOAD_VALUE from a fixed table.
- Pulses the divider's reset whenever the setting changes, so the new rate takes effect immediately rather than after the old count expires.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles needed to accept a button level (10 ms at 100 MHz); the bench uses 4.
- DEFAULT_INDEX, 3, table index loaded on reset; legal range 0..7.

Ports:
- CLK_IN  input  1  system clock, 100 MHz.
- RESET  input  1  synchronous, active-low reset.
- BTN_UP  input  1  raw asynchronous button; press selects the next slower timebase.
- BTN_DOWN  input  1  raw asynchronous button; press selects the next faster timebase.
- LOAD_VALUE  output  28  half-period count for the divider, registered.
- DIV_RESET  output  1  active-high, one-cycle reload strobe to the divider, registered.
- INDEX  output  3  current table index, registered.
- AT_MIN  output  1  INDEX == 0, registered.
- AT_MAX  output  1  INDEX == 7, registered.

Behaviour:
- Table (INDEX -> LOAD_VALUE -> divider output frequency):
  - 0 -> 50 -> 1 MHz
  - 1 -> 500 -> 100 kHz
  - 2 -> 5_000 -> 10 kHz
  - 3 -> 50_000 -> 1 kHz
  - 4 -> 500_000 -> 100 Hz
  - 5 -> 5_000_000 -> 10 Hz
  - 6 -> 50_000_000 -> 1 Hz
  - 7 -> 100_000_000 -> 0.5 Hz
- All values fit in 28 bits; LOAD_VALUE never equals 0.
- Reset values (any clock edge with RESET = 0):
  - INDEX = DEFAULT_INDEX; LOAD_VALUE = table[DEFAULT_INDEX].
  - DIV_RESET = 1; AT_MIN/AT_MAX reflect DEFAULT_INDEX.
  - FSM = IDLE; debounced levels = 0; debounce counters = 0; synchronisers = 0.
  - DIV_RESET returns to 0 on the first edge with RESET = 1.
- Input path, per button:
  - 2-flop synchroniser.
  - Debounce: counter clears whenever the synchronised level equals the debounced level, otherwise increments.
  - When the counter reaches DEBOUNCE_CYCLES - 1, the debounced level toggles and the counter clears.
  - A pulse shorter than DEBOUNCE_CYCLES cycles is never accepted.
- Press event: one-cycle strobe on a 0->1 transition of the debounced level. Release produces no event.
- FSM states IDLE, UPDATE, NOTIFY:
  - IDLE:
    - Exactly one of up_evt/down_evt in cycle E -> UPDATE.
    - Both in the same cycle -> ignored, stay IDLE.
  - UPDATE (edge E+1): INDEX, LOAD_VALUE, AT_MIN and AT_MAX update together. Then:
    - Index actually changed -> NOTIFY.
    - Saturated (UP at 7, DOWN at 0) -> IDLE with no outputs changed.
  - NOTIFY (edge E+2): DIV_RESET = 1 for exactly one cycle, then -> IDLE.
- LOAD_VALUE is stable for at least one full cycle before and during DIV_RESET.
- Events arriving while in UPDATE or NOTIFY are dropped; they are not queued.
- Index arithmetic: 3-bit, saturating at both ends, never wraps.
- Reset mid-operation: RESET = 0 in any state forces all reset values. A pending change is discarded.
- Buttons held indefinitely produce a single event; there is no auto-repeat.

Decomposition:
- Shared package/header `timebase_defs`:
  - LOAD_VALUE table constants TB_LOAD_0..TB_LOAD_7.
  - TB_NUM_STEPS = 8, TB_INDEX_W = 3.
  - FSM state encodings ST_IDLE / ST_UPDATE / ST_NOTIFY.
- One sub-module, `button_debouncer` (parameter DEBOUNCE_CYCLES), instantiated twice.
  - Ports: CLK_IN, RESET, BTN_RAW in; BTN_LEVEL and BTN_PRESS out.
  - Contains the synchroniser, debounce counter and rising-edge strobe.
- Top level holds the FSM, index register and table lookup.

Test Plan (DEBOUNCE_CYCLES = 4):
1. RESET low for 3 cycles, then high, no buttons:
   - INDEX = 3, LOAD_VALUE = 50_000 (0xC350), AT_MIN = AT_MAX = 0.
   - DIV_RESET = 1 during reset and 0 from the first post-reset edge.
2. BTN_UP high for 12 cycles:
   - Exactly one change: INDEX = 4, LOAD_VALUE = 500_000 (0x7A120).
   - DIV_RESET is a single 1-cycle pulse, exactly one cycle after LOAD_VALUE changes.
   - Release produces no further activity.
3. BTN_UP high for 3 cycles only, then low for 20 cycles:
   - INDEX, LOAD_VALUE and DIV_RESET unchanged.
4. Five separate UP presses from INDEX 3:
   - INDEX steps 4, 5, 6, 7, 7; LOAD_VALUE ends at 100_000_000 (0x5F5E100); AT_MAX = 1.
   - Only 4 DIV_RESET pulses.
   - Mirror case: DOWN presses from 0 keep INDEX = 0 and LOAD_VALUE = 50 with no pulse.
5. BTN_UP and BTN_DOWN rising on the same cycle and held 12 cycles:
   - Simultaneous events, no change, no DIV_RESET.
6. UP press, then RESET driven low in the NOTIFY cycle:
   - Next edge gives INDEX = 3, LOAD_VALUE = 50_000, DIV_RESET = 1.
   - After release, FSM is IDLE with no further pulse.

Source files
------------

// File: rtl/timebase_defs.sv
// Shared constants for the timebase selector: load table, widths and FSM states.
// LOAD_VALUE is the divider half-period count for each front-panel step.
package timebase_defs;

   localparam int TB_NUM_STEPS = 8;
   localparam int TB_INDEX_W   = 3;

   localparam logic [27:0] TB_LOAD_0 = 28'd50;
   localparam logic [27:0] TB_LOAD_1 = 28'd500;
   localparam logic [27:0] TB_LOAD_2 = 28'd5_000;
   localparam logic [27:0] TB_LOAD_3 = 28'd50_000;
   localparam logic [27:0] TB_LOAD_4 = 28'd500_000;
   localparam logic [27:0] TB_LOAD_5 = 28'd5_000_000;
   localparam logic [27:0] TB_LOAD_6 = 28'd50_000_000;
   localparam logic [27:0] TB_LOAD_7 = 28'd100_000_000;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_UPDATE = 2'd1,
      ST_NOTIFY = 2'd2
   } state_t;

   function automatic logic [27:0] load_of(
      input logic [TB_INDEX_W-1:0] idx
   );
      load_of = TB_LOAD_0;
      case (idx)
         3'd0: load_of = TB_LOAD_0;
         3'd1: load_of = TB_LOAD_1;
         3'd2: load_of = TB_LOAD_2;
         3'd3: load_of = TB_LOAD_3;
         3'd4: load_of = TB_LOAD_4;
         3'd5: load_of = TB_LOAD_5;
         3'd6: load_of = TB_LOAD_6;
         3'd7: load_of = TB_LOAD_7;
      endcase
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// Raw push-button to clean level plus a one-cycle press strobe.
// Two-flop synchroniser, then a stability counter gating level changes.
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic CLK_IN,
   input  logic RESET,
   input  logic BTN_RAW,
   output logic BTN_LEVEL,
   output logic BTN_PRESS
);

   localparam int CNT_W =
      (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_level;
   logic             r_press;
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge CLK_IN) begin
      if (!RESET) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_level <= 1'b0;
         r_press <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= BTN_RAW;
         r_sync2 <= r_sync1;
         r_press <= 1'b0;
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            // Strobe only on the accepted rising level; release is silent.
            r_level <= ~r_level;
            r_press <= ~r_level;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign BTN_LEVEL = r_level;
   assign BTN_PRESS = r_press;

endmodule

// File: rtl/timebase_selector.sv
// Front-panel UP/DOWN to saturating timebase index, divider load and reload strobe.
// Index and load change together one cycle before the one-cycle DIV_RESET.
module timebase_selector
   import timebase_defs::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int DEFAULT_INDEX   = 3
) (
   input  logic                  CLK_IN,
   input  logic                  RESET,
   input  logic                  BTN_UP,
   input  logic                  BTN_DOWN,
   output logic [27:0]           LOAD_VALUE,
   output logic                  DIV_RESET,
   output logic [TB_INDEX_W-1:0] INDEX,
   output logic                  AT_MIN,
   output logic                  AT_MAX
);

   localparam logic [TB_INDEX_W-1:0] DEF_IDX = TB_INDEX_W'(DEFAULT_INDEX);
   localparam logic [TB_INDEX_W-1:0] IDX_MAX = TB_INDEX_W'(TB_NUM_STEPS - 1);

   logic w_up_level;
   logic w_up_press;
   logic w_dn_level;
   logic w_dn_press;
   logic w_up_evt;
   logic w_dn_evt;

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
      .CLK_IN   (CLK_IN),
      .RESET    (RESET),
      .BTN_RAW  (BTN_UP),
      .BTN_LEVEL(w_up_level),
      .BTN_PRESS(w_up_press)
   );

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn (
      .CLK_IN   (CLK_IN),
      .RESET    (RESET),
      .BTN_RAW  (BTN_DOWN),
      .BTN_LEVEL(w_dn_level),
      .BTN_PRESS(w_dn_press)
   );

   assign w_up_evt = w_up_press & w_up_level;
   assign w_dn_evt = w_dn_press & w_dn_level;

   state_t                  r_state;
   logic                    r_dir_up;
   logic [TB_INDEX_W-1:0]   r_index;
   logic [27:0]             r_load;
   logic                    r_div_rst;
   logic                    r_at_min;
   logic                    r_at_max;

   logic [TB_INDEX_W-1:0]   w_idx_inc;
   logic [TB_INDEX_W-1:0]   w_idx_dec;
   logic [TB_INDEX_W-1:0]   w_idx_nxt;
   logic                    w_changed;

   assign w_idx_inc = (r_index == IDX_MAX) ? r_index : r_index + 1'b1;
   assign w_idx_dec = (r_index == '0) ? r_index : r_index - 1'b1;
   assign w_idx_nxt = r_dir_up ? w_idx_inc : w_idx_dec;
   assign w_changed = (w_idx_nxt != r_index);

   always_ff @(posedge CLK_IN) begin
      if (!RESET) begin
         r_state   <= ST_IDLE;
         r_dir_up  <= 1'b0;
         r_index   <= DEF_IDX;
         r_load    <= load_of(DEF_IDX);
         r_div_rst <= 1'b1;
         r_at_min  <= (DEF_IDX == '0);
         r_at_max  <= (DEF_IDX == IDX_MAX);
      end else begin
         r_div_rst <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               // Simultaneous presses are ambiguous and ignored.
               if (w_up_evt ^ w_dn_evt) begin
                  r_dir_up <= w_up_evt;
                  r_state  <= ST_UPDATE;
               end
            end
            ST_UPDATE: begin
               if (w_changed) begin
                  r_index  <= w_idx_nxt;
                  r_load   <= load_of(w_idx_nxt);
                  r_at_min <= (w_idx_nxt == '0);
                  r_at_max <= (w_idx_nxt == IDX_MAX);
                  r_state  <= ST_NOTIFY;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_NOTIFY: begin
               r_div_rst <= 1'b1;
               r_state   <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign LOAD_VALUE = r_load;
   assign DIV_RESET  = r_div_rst;
   assign INDEX      = r_index;
   assign AT_MIN     = r_at_min;
   assign AT_MAX     = r_at_max;

endmodule

// File: tb/tb_timebase_selector.sv
// Directed bench for timebase_selector with a scoreboard of expected changes.
// A negedge monitor pops each expected index/load change and checks strobe timing.
module tb_timebase_selector;

   logic        clk = 1'b0;
   logic        RESET = 1'b0;
   logic        BTN_UP = 1'b0;
   logic        BTN_DOWN = 1'b0;
   logic [27:0] LOAD_VALUE;
   logic        DIV_RESET;
   logic [2:0]  INDEX;
   logic        AT_MIN;
   logic        AT_MAX;

   timebase_selector #(
      .DEBOUNCE_CYCLES(4),
      .DEFAULT_INDEX  (3)
   ) dut (
      .CLK_IN    (clk),
      .RESET     (RESET),
      .BTN_UP    (BTN_UP),
      .BTN_DOWN  (BTN_DOWN),
      .LOAD_VALUE(LOAD_VALUE),
      .DIV_RESET (DIV_RESET),
      .INDEX     (INDEX),
      .AT_MIN    (AT_MIN),
      .AT_MAX    (AT_MAX)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  idx;
      logic [27:0] load;
   } exp_t;

   logic [27:0] exp_tbl [8] = '{
      28'd50, 28'd500, 28'd5_000, 28'd50_000,
      28'd500_000, 28'd5_000_000, 28'd50_000_000, 28'd100_000_000
   };

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   int   n_pulses = 0;
   int   exp_pulses = 0;
   logic [2:0] exp_idx = 3'd3;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Monitor: reset state as seen by the DUT at each edge.
   logic        rst_at_edge = 1'b0;
   logic [2:0]  prev_idx;
   logic [27:0] prev_load;
   logic        chg_prev = 1'b0;
   logic        chg_now;
   exp_t        e;

   always @(posedge clk) rst_at_edge = RESET;

   always @(negedge clk) begin
      chg_now = 1'b0;
      if (rst_at_edge) begin
         if (LOAD_VALUE !== prev_load || INDEX !== prev_idx) begin
            chg_now = 1'b1;
            if (q.size() == 0) begin
               chk("unexpected_change", {1'b0, INDEX, LOAD_VALUE},
                   {1'b0, prev_idx, prev_load});
            end else begin
               e = q.pop_front();
               chk("change_index", 32'(INDEX), 32'(e.idx));
               chk("change_load", 32'(LOAD_VALUE), 32'(e.load));
               chk("load_before_pulse", 32'(DIV_RESET), 32'd0);
            end
         end
         if (DIV_RESET === 1'b1) begin
            n_pulses++;
            chk("pulse_follows_load", 32'(chg_prev), 32'd1);
         end
      end
      chg_prev  = chg_now;
      prev_idx  = INDEX;
      prev_load = LOAD_VALUE;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input string tag);
      chk({tag, "_index"}, 32'(INDEX), 32'(exp_idx));
      chk({tag, "_load"}, 32'(LOAD_VALUE), 32'(exp_tbl[exp_idx]));
      chk({tag, "_at_min"}, 32'(AT_MIN), 32'(exp_idx == 3'd0));
      chk({tag, "_at_max"}, 32'(AT_MAX), 32'(exp_idx == 3'd7));
      chk({tag, "_pulses"}, n_pulses, exp_pulses);
      chk({tag, "_queue"}, q.size(), 0);
   endtask

   task automatic do_reset();
      RESET = 1'b0;
      cyc(3);
      exp_idx = 3'd3;
      chk("rst_div_reset", 32'(DIV_RESET), 32'd1);
      chk("rst_index", 32'(INDEX), 32'd3);
      chk("rst_load", 32'(LOAD_VALUE), 32'hC350);
      RESET = 1'b1;
      cyc(1);
      chk("rst_release_div", 32'(DIV_RESET), 32'd0);
      chk_state("rst");
   endtask

   task automatic press(input string tag, input logic up, input logic dn);
      automatic logic [2:0] nxt = exp_idx;
      if (up && !dn && exp_idx != 3'd7) nxt = exp_idx + 3'd1;
      else if (dn && !up && exp_idx != 3'd0) nxt = exp_idx - 3'd1;
      if (nxt != exp_idx) begin
         q.push_back('{idx: nxt, load: exp_tbl[nxt]});
         exp_pulses++;
      end
      exp_idx  = nxt;
      BTN_UP   = up;
      BTN_DOWN = dn;
      cyc(12);
      BTN_UP   = 1'b0;
      BTN_DOWN = 1'b0;
      cyc(20);
      chk_state(tag);
   endtask

   initial begin
      cyc(1);
      do_reset();
      cyc(5);
      chk_state("idle");

      press("up_once", 1'b1, 1'b0);
      chk("up_once_load_hex", 32'(LOAD_VALUE), 32'h7A120);

      BTN_UP = 1'b1;
      cyc(3);
      BTN_UP = 1'b0;
      cyc(20);
      chk_state("short_pulse");

      do_reset();
      for (int i = 0; i < 5; i++) press("up_sat", 1'b1, 1'b0);
      chk("up_sat_load_hex", 32'(LOAD_VALUE), 32'h5F5E100);
      chk("up_sat_at_max", 32'(AT_MAX), 32'd1);

      for (int i = 0; i < 9; i++) press("dn_sat", 1'b0, 1'b1);
      chk("dn_sat_load", 32'(LOAD_VALUE), 32'd50);

      press("both", 1'b1, 1'b1);

      // UP from 0 lands on 1; reset arrives on the NOTIFY edge.
      q.push_back('{idx: 3'd1, load: exp_tbl[1]});
      BTN_UP = 1'b1;
      cyc(8);
      chk("mid_update_index", 32'(INDEX), 32'd1);
      RESET  = 1'b0;
      BTN_UP = 1'b0;
      cyc(1);
      chk("mid_rst_index", 32'(INDEX), 32'd3);
      chk("mid_rst_load", 32'(LOAD_VALUE), 32'd50_000);
      chk("mid_rst_div", 32'(DIV_RESET), 32'd1);
      cyc(1);
      RESET = 1'b1;
      cyc(1);
      chk("mid_release_div", 32'(DIV_RESET), 32'd0);
      exp_idx = 3'd3;
      cyc(20);
      chk_state("mid_after");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
